// File: rtl/posit_accum_seq_es3.sv
// Batch sequencer that feeds serialized ES3 products one at a time into positaccum_prod_16_raw_es3
// and hands the final raw sum downstream. Define POSIT_ACCUM_SEQ_TIMEOUT_EN for the per-term watchdog and out_err.
module posit_accum_seq_es3 #(
    parameter int unsigned PW      = 40,
    parameter int unsigned AW      = 48,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned CLR_CYC = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             go,
    output logic             busy,
    input  logic [PW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             acc_clr,
    output logic             acc_start,
    output logic [PW-1:0]    acc_in1,
    input  logic [AW-1:0]    acc_result,
    input  logic             acc_done,
    input  logic             acc_truncated,
    output logic [AW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_trunc
`ifdef POSIT_ACCUM_SEQ_TIMEOUT_EN
    ,
    output logic             out_err
`endif
);

    localparam int unsigned      CLR_W    = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);

    if (CLR_CYC < 1 || TIMEOUT < 2 || AW < 14 || PW < 14) begin : g_bad_cfg
        $error("posit_accum_seq_es3: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_IN,
        WAIT_ACC,
        OUT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [CLR_W-1:0] clr_cnt;

`ifdef POSIT_ACCUM_SEQ_TIMEOUT_EN
    localparam int unsigned     WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd;
    logic            wd_expired;

    assign wd_expired = (wd == WD_LAST);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (go) state_nxt = (cfg_count != '0) ? CLEAR : OUT;
            CLEAR:    if (clr_cnt == CLR_LAST) state_nxt = WAIT_IN;
            WAIT_IN:  if (in_valid && in_ready) state_nxt = WAIT_ACC;
            WAIT_ACC: begin
                if (acc_done) state_nxt = (remaining != '0) ? WAIT_IN : OUT;
`ifdef POSIT_ACCUM_SEQ_TIMEOUT_EN
                else if (wd_expired) state_nxt = OUT;
`endif
            end
            OUT:      if (out_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            clr_cnt   <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            acc_clr   <= 1'b0;
            acc_start <= 1'b0;
            acc_in1   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_trunc <= 1'b0;
`ifdef POSIT_ACCUM_SEQ_TIMEOUT_EN
            wd        <= '0;
            out_err   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            in_ready  <= (state_nxt == WAIT_IN);
            acc_clr   <= (state_nxt == CLEAR);
            out_valid <= (state_nxt == OUT);
            acc_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (go) begin
                        if (cfg_count != '0) begin
                            remaining <= cfg_count;
                            out_trunc <= 1'b0;
                            clr_cnt   <= '0;
                        end else begin
                            // Empty batch: raw zero (only the zero flag set).
                            out_data <= AW'(1);
                        end
`ifdef POSIT_ACCUM_SEQ_TIMEOUT_EN
                        out_err <= 1'b0;
`endif
                    end
                end
                CLEAR: clr_cnt <= clr_cnt + CLR_W'(1);
                WAIT_IN: begin
                    if (in_valid && in_ready) begin
                        acc_in1   <= in_data;
                        acc_start <= 1'b1;
                        remaining <= remaining - CNT_W'(1);
`ifdef POSIT_ACCUM_SEQ_TIMEOUT_EN
                        wd        <= '0;
`endif
                    end
                end
                WAIT_ACC: begin
                    if (acc_done) begin
                        out_trunc <= out_trunc | acc_truncated;
                        if (remaining == '0) out_data <= acc_result;
                    end
`ifdef POSIT_ACCUM_SEQ_TIMEOUT_EN
                    else begin
                        wd <= wd + WD_W'(1);
                        if (wd_expired) begin
                            out_err  <= 1'b1;
                            out_data <= '0;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_accum_seq_es3.sv
// Randomized bench for posit_accum_seq_es3 with an integer-valued accumulator stub and
// a sum-of-terms reference computed from the generated products.
module tb_posit_accum_seq_es3;

    localparam int unsigned PW    = 40;
    localparam int unsigned AW    = 48;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TO    = 20;
    localparam int          FW_P  = PW - 13;
    localparam int          FW_A  = AW - 13;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] cfg_count;
    logic             go;
    logic             busy;
    logic [PW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic             acc_clr;
    logic             acc_start;
    logic [PW-1:0]    acc_in1;
    logic [AW-1:0]    acc_result;
    logic             acc_done;
    logic             acc_truncated;
    logic [AW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_trunc;
`ifdef POSIT_ACCUM_SEQ_TIMEOUT_EN
    logic             out_err;
`endif

    posit_accum_seq_es3 #(
        .PW(PW), .AW(AW), .CNT_W(CNT_W), .CLR_CYC(2), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .cfg_count(cfg_count), .go(go), .busy(busy),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .acc_clr(acc_clr), .acc_start(acc_start), .acc_in1(acc_in1),
        .acc_result(acc_result), .acc_done(acc_done), .acc_truncated(acc_truncated),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_trunc(out_trunc)
`ifdef POSIT_ACCUM_SEQ_TIMEOUT_EN
        , .out_err(out_err)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Exact encoding of an integer as {sgn, scale[9:0], frac[fw-1:0], inf, zero}.
    function automatic logic [63:0] enc(longint v, int fw);
        logic [63:0] r;
        logic [63:0] m;
        int          sc;
        r = '0;
        if (v == 0) begin
            r[0] = 1'b1;
            return r;
        end
        m  = 64'(v < 0 ? -v : v);
        sc = 0;
        for (int i = 0; i < 40; i++) if (m[i]) sc = i;
        r = ((m - (64'd1 << sc)) << (fw - sc)) << 2;
        r = r | (64'(sc) << (fw + 2));
        if (v < 0) r = r | (64'd1 << (fw + 12));
        return r;
    endfunction

    function automatic longint dec(logic [63:0] x, int fw);
        logic [63:0] f;
        int          sc;
        longint      m;
        if (x[0]) return 0;
        sc = int'(x[fw + 2 +: 10]);
        f  = (x >> 2) & ((64'd1 << fw) - 64'd1);
        m  = longint'((64'd1 << sc) + (f >> (fw - sc)));
        return x[fw + 12] ? -m : m;
    endfunction

    // Accumulator stub: sums decoded products, answers each start after stub_lat cycles.
    int     stub_lat    = 2;
    bit     stub_silent = 0;
    bit     trunc_en    = 0;
    bit     tr_roll;
    int     stub_cnt;
    longint stub_sum;
    int     n_start = 0;
    int     n_trunc = 0;

    always @(negedge clk) tr_roll <= ($urandom_range(0, 3) == 0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_done      <= 1'b0;
            acc_truncated <= 1'b0;
            acc_result    <= '0;
            stub_cnt      <= 0;
            stub_sum      <= 0;
        end else begin
            acc_done <= 1'b0;
            if (acc_clr) begin
                stub_sum <= 0;
                stub_cnt <= 0;
            end else if (acc_start) begin
                stub_sum <= stub_sum + dec(64'(acc_in1), FW_P);
                stub_cnt <= stub_lat;
                n_start  <= n_start + 1;
            end else if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1 && !stub_silent) begin
                    acc_done      <= 1'b1;
                    acc_result    <= AW'(enc(stub_sum, FW_A));
                    acc_truncated <= tr_roll && trunc_en;
                    if (tr_roll && trunc_en) n_trunc <= n_trunc + 1;
                end
            end
        end
    end

    // While a term is in flight the sequencer must not accept another product.
    always @(negedge clk) begin
        if (rst && stub_cnt > 0) check("ready_in_wait_acc", 64'(in_ready), 64'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    longint prods[$];
    bit     model_trunc = 0;

    task automatic run_batch(int stall, bit go_in_stall);
        int     n;
        int     s0;
        int     t0;
        int     cyc;
        longint sum;
        n   = prods.size();
        s0  = n_start;
        t0  = n_trunc;
        sum = 0;
        foreach (prods[i]) sum += prods[i];
        @(negedge clk);
        cfg_count = CNT_W'(n);
        go        = 1'b1;
        @(negedge clk);
        go        = 1'b0;
        cfg_count = CNT_W'($urandom);
        fork
            begin : producer
                int idx = 0;
                int budget = 0;
                while (idx < n && budget < 5000) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        in_data  = PW'({$urandom, $urandom});
                    end else begin
                        in_valid = 1'b1;
                        in_data  = PW'(enc(prods[idx], FW_P));
                    end
                    if (in_valid && in_ready) idx++;
                    @(negedge clk);
                    budget++;
                end
                in_valid = 1'b0;
            end
            begin : consumer
                cyc = 0;
                while (!out_valid && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                end
                if (n == 0) check("zero_latency", 64'(cyc <= 2), 64'd1);
                else model_trunc = (n_trunc != t0);
                check("out_valid", 64'(out_valid), 64'd1);
                check("out_data", 64'(out_data), enc(sum, FW_A));
                check("out_trunc", 64'(out_trunc), 64'(model_trunc));
                check("start_count", 64'(n_start - s0), 64'(n));
                for (int k = 0; k < stall; k++) begin
                    cfg_count = CNT_W'(3);
                    go        = go_in_stall && (k == 1);
                    @(negedge clk);
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_data", 64'(out_data), enc(sum, FW_A));
                end
                go        = 1'b0;
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                check("valid_drop", 64'(out_valid), 64'd0);
                check("idle_after", 64'(busy), 64'd0);
                if (n > 0) check("acc_in1_hold", 64'(acc_in1), enc(prods[n - 1], FW_P));
            end
        join
    endtask

    initial begin
        int cyc;
        rst       = 1'b0;
        go        = 1'b0;
        cfg_count = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({busy, in_ready, acc_clr, acc_start, out_valid, out_trunc}), 64'd0);
        check("reset_in1", 64'(acc_in1), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        rst = 1'b1;

        prods = '{1, 2, 3};
        run_batch(0, 0);

        prods = '{};
        run_batch(1, 0);

        prods = '{4, -1};
        run_batch(5, 1);

        // Abandon a 3-term batch while a term is in flight.
        @(negedge clk);
        cfg_count = CNT_W'(3);
        go        = 1'b1;
        @(negedge clk);
        go        = 1'b0;
        in_valid  = 1'b1;
        in_data   = PW'(enc(9, FW_P));
        cyc = 0;
        while (stub_cnt == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_wait_acc", 64'(stub_cnt != 0), 64'd1);
        in_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("async_rst_ctrl", 64'({busy, in_ready, acc_clr, acc_start, out_valid, out_trunc}), 64'd0);
        check("async_rst_in1", 64'(acc_in1), 64'd0);
        check("async_rst_data", 64'(out_data), 64'd0);
        model_trunc = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        prods = '{1};
        run_batch(1, 0);

        trunc_en = 1;
        for (int r = 0; r < 12; r++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            prods = '{};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) prods.push_back(0);
                else prods.push_back(longint'($urandom_range(0, 400)) - 200);
            end
            stub_lat = int'($urandom_range(1, 4));
            run_batch(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end
        trunc_en = 0;

`ifdef POSIT_ACCUM_SEQ_TIMEOUT_EN
        stub_silent = 1;
        stub_lat    = 2;
        @(negedge clk);
        cfg_count = CNT_W'(1);
        go        = 1'b1;
        @(negedge clk);
        go        = 1'b0;
        in_valid  = 1'b1;
        in_data   = PW'(enc(5, FW_P));
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_latency", 64'(cyc), 64'(TO + 1));
        check("timeout_err", 64'(out_err), 64'd1);
        check("timeout_data", 64'(out_data), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready   = 1'b0;
        stub_silent = 0;
        prods = '{7};
        run_batch(0, 0);
        check("err_cleared", 64'(out_err), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
